// File: rtl/stopwatch_up.sv
// stopwatch_up: up-counting M:SS stopwatch with BCD limit and buzzer; define LAP_EN to enable the lap-freeze display
module stopwatch_up #(
  parameter int TICK_DIV = 1000
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [3:0] PSW,
  input  logic [3:0] RSW,
  output logic [7:0] SEG_A,
  output logic [7:0] SEG_B,
  output logic [7:0] SEG_C,
  output logic [7:0] SEG_D,
  output logic [7:0] LED,
  output logic       BZ
);
  localparam int PW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LIMIT} state_t;
  state_t state, state_n;
  logic [PW-1:0] pre, pre_n;
  logic [3:0] psw_q, press, lim;
  logic [3:0] mn, st, su, mn_n, st_n, su_n, mn_i, st_i, su_i;
  logic tick, hit;
  logic lap, lap_n;
  logic [3:0] lmn, lst, lsu;
  logic unused_press;
  assign unused_press = ^press[3:2];

  function automatic logic [7:0] enc(input logic [3:0] d);
    case (d)
      4'd0: enc = 8'h3F;
      4'd1: enc = 8'h06;
      4'd2: enc = 8'h5B;
      4'd3: enc = 8'h4F;
      4'd4: enc = 8'h66;
      4'd5: enc = 8'h6D;
      4'd6: enc = 8'h7D;
      4'd7: enc = 8'h07;
      4'd8: enc = 8'h7F;
      4'd9: enc = 8'h6F;
      default: enc = 8'h00;
    endcase
  endfunction

  always_comb begin
    press = PSW & ~psw_q;
    lim = (RSW <= 4'd9) ? RSW : 4'd0;
    tick = pre == PW'(TICK_DIV - 1);
    su_i = (su == 4'd9) ? 4'd0 : su + 4'd1;
    st_i = (su != 4'd9) ? st : (st == 4'd5) ? 4'd0 : st + 4'd1;
    mn_i = (su != 4'd9 || st != 4'd5) ? mn : (mn == 4'd9) ? 4'd0 : mn + 4'd1;
    // limit is matched on the freshly incremented value, so a limit already passed waits for wrap
    hit = tick && lim != 4'd0 && mn_i == lim && st_i == 4'd0 && su_i == 4'd0;
    state_n = state;
    pre_n = pre;
    {mn_n, st_n, su_n} = {mn, st, su};
    case (state)
      IDLE: if (press[0]) begin
        state_n = RUN;
        pre_n = '0;
      end
      RUN: begin
        pre_n = tick ? '0 : pre + 1'b1;
        if (tick) {mn_n, st_n, su_n} = {mn_i, st_i, su_i};
        state_n = hit ? LIMIT : press[0] ? PAUSE : RUN;
      end
      PAUSE: if (press[1]) begin
        state_n = IDLE;
        pre_n = '0;
        {mn_n, st_n, su_n} = '0;
      end else if (press[0]) state_n = RUN;
      LIMIT: if (press[1]) begin
        state_n = IDLE;
        pre_n = '0;
        {mn_n, st_n, su_n} = '0;
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef LAP_EN
  always_comb
    lap_n = (state == RUN) ? (hit ? 1'b0 : press[0] ? lap : press[2] ? ~lap : lap)
          : (state == PAUSE && press[1]) ? 1'b0 : lap;

  always_ff @(posedge CLOCK)
    if (!RESET) {lap, lmn, lst, lsu} <= '0;
    else begin
      lap <= lap_n;
      if (lap_n && !lap) {lmn, lst, lsu} <= {mn, st, su};
    end
`else
  assign lap = 1'b0;
  assign lap_n = 1'b0;
  assign {lmn, lst, lsu} = '0;
`endif

  always_ff @(posedge CLOCK)
    if (!RESET) begin
      state <= IDLE;
      pre <= '0;
      psw_q <= '0;
      {mn, st, su} <= '0;
      SEG_A <= 8'h00;
      SEG_B <= 8'h3F;
      SEG_C <= 8'h3F;
      SEG_D <= 8'h3F;
      LED <= 8'h00;
      BZ <= 1'b0;
    end else begin
      state <= state_n;
      pre <= pre_n;
      psw_q <= PSW;
      {mn, st, su} <= {mn_n, st_n, su_n};
      SEG_A <= lap ? 8'h38 : 8'h00;
      SEG_B <= enc(lap ? lmn : mn);
      SEG_C <= enc(lap ? lst : st);
      SEG_D <= enc(lap ? lsu : su);
      LED <= {4'h0, lap_n, state_n == LIMIT, state_n == PAUSE, state_n == RUN};
      BZ <= (state_n == LIMIT) && !BZ;
    end
endmodule

// File: tb/tb_stopwatch_up.sv
// tb_stopwatch_up: scoreboard bench comparing stopwatch_up against a seconds-based reference model
module tb_stopwatch_up;
  localparam int TD = 4;
  logic clk = 1'b0;
  logic RESET = 1'b0;
  logic [3:0] PSW = '0, RSW = '0;
  logic [7:0] SEG_A, SEG_B, SEG_C, SEG_D, LED;
  logic BZ;

  always #5 clk = ~clk;

  stopwatch_up #(.TICK_DIV(TD)) dut (
    .CLOCK(clk), .RESET(RESET), .PSW(PSW), .RSW(RSW),
    .SEG_A(SEG_A), .SEG_B(SEG_B), .SEG_C(SEG_C), .SEG_D(SEG_D),
    .LED(LED), .BZ(BZ)
  );

  typedef struct {
    logic [7:0] a, b, c, d, led;
    logic bz;
  } exp_t;
  exp_t q[$];
  int errors = 0, checks = 0, cycle = 0;

  // reference model: count kept as total seconds, mode as a small integer
  int mode = 0;  // 0 idle, 1 running, 2 paused, 3 at limit
  int secs = 0, pre = 0, lap_secs = 0, cur_rsw = 0;
  bit lap = 0, bz = 0;
  logic [3:0] prev = '0;

  function automatic logic [7:0] seg(input int d);
    logic [7:0] tbl [10];
    tbl = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
    return tbl[d];
  endfunction

  task automatic model(input logic [3:0] psw, input logic [3:0] rsw, input logic rst_n);
    exp_t e;
    logic [3:0] pr;
    int shown, lim, old;
    if (!rst_n) begin
      mode = 0; secs = 0; pre = 0; lap = 0; lap_secs = 0; bz = 0; prev = '0;
      e = '{8'h00, 8'h3F, 8'h3F, 8'h3F, 8'h00, 1'b0};
    end else begin
      pr = psw & ~prev;
      prev = psw;
      shown = lap ? lap_secs : secs;
      e.a = lap ? 8'h38 : 8'h00;
      e.b = seg(shown / 60);
      e.c = seg((shown % 60) / 10);
      e.d = seg(shown % 10);
      lim = (rsw >= 1 && rsw <= 9) ? int'(rsw) : 0;
      old = secs;
      case (mode)
        0: if (pr[0]) begin mode = 1; pre = 0; end
        1: begin
          if (pre == TD - 1) begin
            pre = 0;
            secs = (secs + 1) % 600;
            if (lim != 0 && secs == lim * 60) begin mode = 3; lap = 0; end
          end else pre++;
          if (mode == 1 && pr[0]) mode = 2;
`ifdef LAP_EN
          else if (mode == 1 && pr[2]) begin
            if (lap) lap = 0;
            else begin lap = 1; lap_secs = old; end
          end
`endif
        end
        2: if (pr[1]) begin mode = 0; secs = 0; pre = 0; lap = 0; end
           else if (pr[0]) mode = 1;
        default: if (pr[1]) begin mode = 0; secs = 0; pre = 0; end
      endcase
      bz = (mode == 3) ? !bz : 1'b0;
      e.led = {4'h0, lap, mode == 3, mode == 2, mode == 1};
      e.bz = bz;
    end
    q.push_back(e);
  endtask

  task automatic cyc(input logic [3:0] psw, input logic [3:0] rsw, input logic rst_n);
    @(negedge clk);
    PSW = psw;
    RSW = rsw;
    RESET = rst_n;
    model(psw, rsw, rst_n);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(4'h0, 4'(cur_rsw), 1'b1);
  endtask

  task automatic push(input logic [3:0] m);
    cyc(m, 4'(cur_rsw), 1'b1);
    cyc(4'h0, 4'(cur_rsw), 1'b1);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cycle, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    cycle++;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("SEG_A", SEG_A, e.a);
      chk("SEG_B", SEG_B, e.b);
      chk("SEG_C", SEG_C, e.c);
      chk("SEG_D", SEG_D, e.d);
      chk("LED", LED, e.led);
      chk("BZ", {7'h0, BZ}, {7'h0, e.bz});
    end
  end

  initial begin
    cyc(4'h0, 4'h0, 1'b0);
    cyc(4'h0, 4'h0, 1'b0);
    idle(2);
    push(4'h1);
    idle(40);
    push(4'h1);
    push(4'h2);
    cur_rsw = 1;
    push(4'h1);
    idle(250);
    push(4'h1);
    idle(3);
    push(4'h2);
    idle(3);
    cur_rsw = 0;
    push(4'h1);
    idle(2420);
    push(4'h1);
    push(4'h2);
    push(4'h1);
    idle(18);
    push(4'h4);
    idle(30);
    push(4'h4);
    idle(10);
    push(4'h4);
    push(4'h1);
    idle(6);
    push(4'h4);
    push(4'h1);
    idle(4);
    repeat (5) cyc(4'h1, 4'h0, 1'b1);
    idle(3);
    push(4'h1);
    cyc(4'h3, 4'h0, 1'b1);
    idle(3);
    push(4'h1);
    idle(10);
    cyc(4'h0, 4'h0, 1'b0);
    idle(4);
    cur_rsw = 12;
    push(4'h1);
    idle(50);
    push(4'h1);
    push(4'h2);
    for (int i = 0; i < 6000; i++) begin
      logic [3:0] p;
      p = PSW;
      if ($urandom_range(0, 199) == 0) cur_rsw = $urandom_range(0, 15);
      if ($urandom_range(0, 7) == 0) begin
        p = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 3) != 0) p[1] = 1'b0;
      end else if ($urandom_range(0, 2) == 0) p = 4'h0;
      cyc(p, 4'(cur_rsw), ($urandom_range(0, 999) != 0));
    end
    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d left expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
